alu_mc: RTL
===========

# alu_mc

Multi-cycle ALU responder for the CPU datapath: accepts one operation per request over a valid/ready handshake, computes it (shifts iteratively, one bit per cycle), and returns the result over a second valid/ready handshake. It serves the same 4-bit opcode set and `c`/`zero` result convention as the single-cycle `alu`. It is intended for a multi-cycle execute stage or an ALU co-processor port where area matters more than shift latency.

## Interface
- No parameters; data width fixed at 32, opcode width at 4.
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `req_valid` in 1 — request operands/opcode valid.
- `req_ready` out 1 — block can accept a request.
- `a` in 32 — operand A (shift source for SLL/SRL/SRA).
- `b` in 32 — operand B (shift amount = `b[4:0]`; LUI source = `b[15:0]`).
- `aluop` in 4 — opcode: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLL 6, SRL 7, SRA 8, LUI 9, SLT 10, SLTU 11, BGTZ 12; 13–15 illegal.
- `resp_valid` out 1 — result valid.
- `resp_ready` in 1 — consumer accepts result.
- `c` out 32 — result.
- `zero` out 2 — `[0]` = (c == 0); `[1]` = BGTZ taken (signed a > 0), 0 for other ops.
- `err` out 1 — request carried an illegal opcode; valid with `resp_valid`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `a`, `b[4:0]`, `aluop`.
  - Non-shift op, or shift with `b[4:0]`==0: compute result, go DONE.
  - SLL/SRL/SRA with n=`b[4:0]`>0: load shift reg with `a`, counter with n, go SHIFT.
- SHIFT: each cycle shift one bit (SLL: left, 0 in; SRL: right, 0 in; SRA: right, bit 31 replicated), decrement counter; on counter reaching 0 go DONE.
- DONE: `resp_valid`=1, `c`/`zero`/`err` stable; on `resp_ready` go IDLE. Outputs must not change while `resp_valid`=1 and `resp_ready`=0.
- Arithmetic: ADD/SUB modulo 2^32, no overflow flag. SLT signed compare, SLTU unsigned; result 32'd1 or 32'd0. LUI: `{b[15:0],16'h0}`. NOR: ~(a|b). BGTZ: c = {31'b0, a>0 signed}, `zero[1]` = same bit.
- Illegal opcode: c=0, `zero`=2'b01, `err`=1, latency as non-shift op.
- `req_ready` is 0 in SHIFT and DONE; requests there are ignored (not queued).

## Timing
- Reset (`rst_n`=0 at rising edge): state IDLE, `req_ready`=1 after reset, `resp_valid`=0, `c`=0, `zero`=0, `err`=0, counter cleared. Reset mid-SHIFT or in DONE abandons the operation; no response issued.
- Non-shift latency: request accepted at edge k → `resp_valid`=1 in the cycle after edge k.
- Shift latency: n>0 → `resp_valid`=1 after edge k+n (n SHIFT cycles). Max 31 SHIFT cycles.
- Response handshake at edge m → IDLE, `resp_valid`=0 and `req_ready`=1 in the following cycle; next request no earlier than edge m+1. Peak throughput one op per 2 cycles.
- `resp_ready` held high with `resp_valid` does not shorten latency.
- `zero` and `err` are registered with `c`; no combinational path from inputs to outputs.

## Test plan
- ADD a=5, b=4 → one cycle after accept: c=9, zero=2'b00; SUB 5,5 → c=0, zero=2'b01.
- SLL a=32'hff000000, b=4 → 4 SHIFT cycles, resp_valid after edge k+4, c=32'hf0000000; SRA same operands → c=32'hfff00000; SRL b=0 → 1-cycle latency, c=a.
- SLT a=32'hffffffff, b=0 → c=1; SLTU same → c=0; BGTZ a=5 → c=1, zero=2'b10; BGTZ a=32'h80000000 → c=0, zero=2'b01.
- XOR 32'h0f0f0f0f ^ 32'h0c0c0c0c → c=32'h03030303; aluop=4'd14 → c=0, err=1.
- Back-pressure: hold resp_ready=0 for 5 cycles in DONE, drive new req_valid → req_ready=0, c stable, second request not taken until after response handshake.
- Reset mid-SHIFT (SLL b=20, rst_n low at cycle 3) → resp_valid never asserts, all outputs 0, req_ready=1 the cycle after rst_n returns high.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with request/response handshakes and bit-serial shifts
module alu_mc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluop,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] c,
  output logic [1:0]  zero,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [3:0]  op;
  logic [4:0]  cnt;
  logic [31:0] res, shv;
  logic        acc, sh_start, gtz, ill;
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == DONE;
    acc        = req_valid && state == IDLE;
    sh_start   = acc && (aluop == 4'd6 || aluop == 4'd7 || aluop == 4'd8) && |b[4:0];
    gtz        = !a[31] && |a;
    ill        = aluop > 4'd12;
    nxt        = state == IDLE  ? (acc ? (sh_start ? SHIFT : DONE) : IDLE) :
                 state == SHIFT ? (cnt == 5'd1 ? DONE : SHIFT) :
                 state == DONE  ? (resp_ready ? IDLE : DONE) : IDLE;
    shv        = op == 4'd6 ? {c[30:0], 1'b0} : {op == 4'd8 && c[31], c[31:1]};
    case (aluop)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = ~(a | b);
      4'd9:    res = {b[15:0], 16'h0};
      4'd10:   res = {31'b0, $signed(a) < $signed(b)};
      4'd11:   res = {31'b0, a < b};
      4'd12:   res = {31'b0, gtz};
      4'd6, 4'd7, 4'd8: res = a;
      default: res = 32'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= 4'd0;
      cnt   <= 5'd0;
      c     <= 32'd0;
      zero  <= 2'b00;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        op   <= aluop;
        cnt  <= b[4:0];
        c    <= sh_start ? a : res;
        zero <= sh_start ? 2'b00 : {aluop == 4'd12 && gtz, res == 32'd0};
        err  <= ill;
      end else if (state == SHIFT) begin
        c   <= shv;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) zero <= {1'b0, shv == 32'd0};
      end
    end
  end
endmodule
